// File: rtl/system_bus_pkg.sv
// ---------------------------------------------------------------------------
// system_bus_pkg
//   Shared widths, FSM state type and the stall-LFSR step function for the
//   system bus RAM responder and its helpers.
// ---------------------------------------------------------------------------
package system_bus_pkg;

   localparam int unsigned SYSTEM_BUS_ADDR_WIDTH        = 30;
   localparam int unsigned SYSTEM_BUS_DATA_WIDTH        = 32;
   localparam int unsigned SYSTEM_BUS_BYTE_ENABLE_WIDTH = 4;
   localparam int unsigned STALL_LFSR_WIDTH             = 16;

   typedef enum logic {
      INIT,
      RUN
   } system_bus_ram_state_t;

   // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 (maximal length, so a
   // nonzero seed never reaches the all-zero lock-up state).
   function automatic logic [STALL_LFSR_WIDTH-1:0] stall_lfsr_next(
      input logic [STALL_LFSR_WIDTH-1:0] cur
   );
      return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
   endfunction

endpackage

// File: rtl/system_bus_delay_line.sv
// ---------------------------------------------------------------------------
// system_bus_delay_line
//   {valid,data} shift pipeline of STAGES registers. A data stage only loads
//   when the valid bit in front of it is set, so out_data keeps the last
//   valid word while out_valid is low. STAGES = 0 is a plain pass-through.
// Ports
//   clk        in   1      clock
//   reset_n    in   1      asynchronous active-low reset (clears all stages)
//   in_valid   in   1      valid entering the pipeline
//   in_data    in   WIDTH  data entering the pipeline
//   out_valid  out  1      valid leaving the pipeline
//   out_data   out  WIDTH  data leaving the pipeline
// ---------------------------------------------------------------------------
module system_bus_delay_line #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   generate
      if (STAGES == 0) begin : g_pass
         assign out_valid = in_valid;
         assign out_data  = in_data;
      end else begin : g_pipe
         logic [STAGES-1:0] valid_q;
         logic [WIDTH-1:0]  data_q [STAGES];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               valid_q <= '0;
               for (int unsigned i = 0; i < STAGES; i++) begin
                  data_q[i] <= '0;
               end
            end else begin
               valid_q[0] <= in_valid;
               if (in_valid) begin
                  data_q[0] <= in_data;
               end
               for (int unsigned i = 1; i < STAGES; i++) begin
                  valid_q[i] <= valid_q[i-1];
                  if (valid_q[i-1]) begin
                     data_q[i] <= data_q[i-1];
                  end
               end
            end
         end

         assign out_valid = valid_q[STAGES-1];
         assign out_data  = data_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/system_bus_ram.sv
// ---------------------------------------------------------------------------
// system_bus_ram
//   Responder end of the system bus: word-addressed on-chip RAM serving CPU
//   fetch/load/store requests. One read or write accepted per cycle while
//   ready; read data returned in order READ_LATENCY cycles after accept.
//   After every reset the array is zeroed (INIT, DEPTH cycles) before the
//   bus is served. Optional pseudo-random stalls drop ready in RUN.
// Ports
//   clk                         in   1   clock
//   reset_n                     in   1   asynchronous active-low reset
//   system_bus_ready            out  1   request accepted this cycle if high
//   system_bus_addr             in   30  word address (low log2(DEPTH) bits used)
//   system_bus_write_data       in   32  store data
//   system_bus_byte_enable      in   4   per-byte write enables
//   system_bus_write_req        in   1   write request
//   system_bus_read_req         in   1   read request
//   system_bus_read_data        out  32  read response data (held when not valid)
//   system_bus_read_data_valid  out  1   one-cycle pulse per accepted read
// ---------------------------------------------------------------------------
module system_bus_ram
   import system_bus_pkg::*;
#(
   parameter int unsigned                    DEPTH        = 1024,
   parameter int unsigned                    READ_LATENCY = 1,
   parameter int unsigned                    STALL_ENABLE = 0,
   parameter logic [STALL_LFSR_WIDTH-1:0]    LFSR_SEED    = 16'hACE1
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   output logic                                    system_bus_ready,
   input  logic [SYSTEM_BUS_ADDR_WIDTH-1:0]        system_bus_addr,
   input  logic [SYSTEM_BUS_DATA_WIDTH-1:0]        system_bus_write_data,
   input  logic [SYSTEM_BUS_BYTE_ENABLE_WIDTH-1:0] system_bus_byte_enable,
   input  logic                                    system_bus_write_req,
   input  logic                                    system_bus_read_req,
   output logic [SYSTEM_BUS_DATA_WIDTH-1:0]        system_bus_read_data,
   output logic                                    system_bus_read_data_valid
);

   localparam int unsigned       IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   system_bus_ram_state_t               state;
   logic [IDX_W-1:0]                    init_cnt;
   logic [STALL_LFSR_WIDTH-1:0]         lfsr;
   logic                                stall;
   logic                                accept_wr;
   logic                                accept_rd;
   logic [IDX_W-1:0]                    word_idx;
   logic                                addr_unused;

   logic [IDX_W-1:0]                        ram_addr;
   logic                                    ram_we;
   logic [SYSTEM_BUS_BYTE_ENABLE_WIDTH-1:0] ram_be;
   logic [SYSTEM_BUS_DATA_WIDTH-1:0]        ram_wdata;
   logic [SYSTEM_BUS_DATA_WIDTH-1:0]        mem [DEPTH];

   logic                                rd_valid_q;
   logic [SYSTEM_BUS_DATA_WIDTH-1:0]    rd_data_q;

   // Upper address bits alias onto the same words.
   assign word_idx = system_bus_addr[IDX_W-1:0];
   generate
      if (IDX_W < SYSTEM_BUS_ADDR_WIDTH) begin : g_alias
         assign addr_unused = ^system_bus_addr[SYSTEM_BUS_ADDR_WIDTH-1:IDX_W];
      end else begin : g_no_alias
         assign addr_unused = 1'b0;
      end
   endgenerate

   // Ready comes from registers only, never from the request inputs.
   assign stall            = (STALL_ENABLE != 0) && lfsr[1] && lfsr[0];
   assign system_bus_ready = (state == RUN) && !stall;

   // A simultaneous write+read is treated as a write; the read is dropped.
   assign accept_wr = system_bus_ready && system_bus_write_req;
   assign accept_rd = system_bus_ready && system_bus_read_req && !system_bus_write_req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= INIT;
         init_cnt <= '0;
         lfsr     <= LFSR_SEED;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + IDX_W'(1);
               if (init_cnt == LAST_IDX) begin
                  state <= RUN;
               end
            end
            RUN: begin
               lfsr <= stall_lfsr_next(lfsr);
            end
            default: state <= INIT;
         endcase
      end
   end

   // INIT borrows the single RAM port to write zeros; bus writes own it in RUN.
   always_comb begin
      ram_addr  = word_idx;
      ram_we    = accept_wr;
      ram_be    = system_bus_byte_enable;
      ram_wdata = system_bus_write_data;
      if (state == INIT) begin
         ram_addr  = init_cnt;
         ram_we    = 1'b1;
         ram_be    = '1;
         ram_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int unsigned b = 0; b < SYSTEM_BUS_BYTE_ENABLE_WIDTH; b++) begin
            if (ram_be[b]) begin
               mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end
      end
   end

   // First read stage: samples the array at the accepting edge, so it sees
   // every write accepted on an earlier edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= accept_rd;
         if (accept_rd) begin
            rd_data_q <= mem[ram_addr];
         end
      end
   end

   system_bus_delay_line #(
      .WIDTH  (SYSTEM_BUS_DATA_WIDTH),
      .STAGES (READ_LATENCY - 1)
   ) u_read_delay (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (rd_valid_q),
      .in_data   (rd_data_q),
      .out_valid (system_bus_read_data_valid),
      .out_data  (system_bus_read_data)
   );

endmodule

// File: tb/tb_system_bus_ram.sv
module tb_system_bus_ram;

   localparam int C_DEPTH = 64;
   localparam int C_LAT   = 2;
   localparam int C_OPS   = 2000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // instance A: DEPTH=16, LAT=1; instance B: DEPTH=16, LAT=3; instance C: DEPTH=64, LAT=2, stalls
   logic        a_rst_n, a_ready, a_wr, a_rd, a_rvalid;
   logic [29:0] a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic [3:0]  a_be;
   logic        b_rst_n, b_ready, b_wr, b_rd, b_rvalid;
   logic [29:0] b_addr;
   logic [31:0] b_wdata, b_rdata;
   logic [3:0]  b_be;
   logic        c_rst_n, c_ready, c_wr, c_rd, c_rvalid;
   logic [29:0] c_addr;
   logic [31:0] c_wdata, c_rdata;
   logic [3:0]  c_be;

   system_bus_ram #(.DEPTH(16), .READ_LATENCY(1), .STALL_ENABLE(0)) u_a (
      .clk(clk), .reset_n(a_rst_n), .system_bus_ready(a_ready), .system_bus_addr(a_addr),
      .system_bus_write_data(a_wdata), .system_bus_byte_enable(a_be),
      .system_bus_write_req(a_wr), .system_bus_read_req(a_rd),
      .system_bus_read_data(a_rdata), .system_bus_read_data_valid(a_rvalid));

   system_bus_ram #(.DEPTH(16), .READ_LATENCY(3), .STALL_ENABLE(0)) u_b (
      .clk(clk), .reset_n(b_rst_n), .system_bus_ready(b_ready), .system_bus_addr(b_addr),
      .system_bus_write_data(b_wdata), .system_bus_byte_enable(b_be),
      .system_bus_write_req(b_wr), .system_bus_read_req(b_rd),
      .system_bus_read_data(b_rdata), .system_bus_read_data_valid(b_rvalid));

   system_bus_ram #(.DEPTH(C_DEPTH), .READ_LATENCY(C_LAT), .STALL_ENABLE(1)) u_c (
      .clk(clk), .reset_n(c_rst_n), .system_bus_ready(c_ready), .system_bus_addr(c_addr),
      .system_bus_write_data(c_wdata), .system_bus_byte_enable(c_be),
      .system_bus_write_req(c_wr), .system_bus_read_req(c_rd),
      .system_bus_read_data(c_rdata), .system_bus_read_data_valid(c_rvalid));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] be);
      a_addr = addr; a_wdata = data; a_be = be; a_wr = 1'b1;
      tick();
      a_wr = 1'b0;
   endtask

   // LAT=1: valid is visible right after the accepting edge, gone one cycle later.
   task automatic a_read(input string tag, input logic [29:0] addr, input logic [31:0] exp);
      a_addr = addr; a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      check({tag, "_valid"}, 32'(a_rvalid), 32'd1);
      check({tag, "_data"}, a_rdata, exp);
      tick();
      check({tag, "_pulse"}, 32'(a_rvalid), 32'd0);
      check({tag, "_hold"}, a_rdata, exp);
   endtask

   // reference model for instance C: word array plus queue of due responses
   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_exp_t;

   logic [31:0] model [C_DEPTH];
   rd_exp_t     rq [$];
   logic [31:0] c_last = '0;

   task automatic c_monitor();
      logic exp_v;
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      check("c_rd_valid", 32'(c_rvalid), 32'(exp_v));
      if (exp_v) begin
         check("c_rd_data", c_rdata, rq[0].data);
         c_last = rq[0].data;
         void'(rq.pop_front());
      end else begin
         check("c_rd_hold", c_rdata, c_last);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r, ops, guard, run_cyc, stall_cyc, idx;
      logic have;

      a_rst_n = 0; a_wr = 0; a_rd = 0; a_addr = '0; a_wdata = '0; a_be = '0;
      b_rst_n = 0; b_wr = 0; b_rd = 0; b_addr = '0; b_wdata = '0; b_be = '0;
      c_rst_n = 0; c_wr = 0; c_rd = 0; c_addr = '0; c_wdata = '0; c_be = '0;
      repeat (3) tick();

      // ---- reset values and INIT duration (A) ----
      check("a_rst_ready", 32'(a_ready), 32'd0);
      check("a_rst_valid", 32'(a_rvalid), 32'd0);
      check("a_rst_data", a_rdata, 32'd0);
      check("c_rst_ready", 32'(c_ready), 32'd0);
      a_rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("a_init_ready", 32'(a_ready), 32'd0);
         tick();
      end
      check("a_run_ready", 32'(a_ready), 32'd1);
      a_read("t1_rd5", 30'd5, 32'h0);

      // ---- byte enables ----
      a_write(30'd3, 32'hDEADBEEF, 4'b1111);
      a_write(30'd3, 32'h000000AA, 4'b0001);
      a_read("t2_merge", 30'd3, 32'hDEADBEAA);
      a_write(30'd3, 32'hFFFFFFFF, 4'b0000);
      a_read("t2_be0", 30'd3, 32'hDEADBEAA);

      // ---- aliasing and write+read collision ----
      a_write(30'd18, 32'h12345678, 4'b1111);
      a_read("t4_alias", 30'd2, 32'h12345678);
      a_read("t4_alias_hi", 30'h12345672, 32'h12345678);
      a_addr = 30'd4; a_wdata = 32'h00000055; a_be = 4'b1111; a_wr = 1'b1; a_rd = 1'b1;
      tick();
      a_wr = 1'b0; a_rd = 1'b0;
      check("t4_both_novalid", 32'(a_rvalid), 32'd0);
      check("t4_both_hold", a_rdata, 32'h12345678);
      tick();
      check("t4_both_novalid2", 32'(a_rvalid), 32'd0);
      a_read("t4_both_wr", 30'd4, 32'h00000055);

      // ---- LAT=3 back-to-back reads (B) ----
      b_rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("b_init_ready", 32'(b_ready), 32'd0);
         tick();
      end
      check("b_run_ready", 32'(b_ready), 32'd1);
      b_wr = 1'b1; b_be = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         b_addr = 30'(i); b_wdata = 32'(i);
         tick();
      end
      b_wr = 1'b0;
      b_addr = 30'd0; b_rd = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k + 1 < 8) b_addr = 30'(k + 1);
         else b_rd = 1'b0;
         check("t3_valid", 32'(b_rvalid), 32'((k >= 2) && (k <= 9)));
         if (k >= 2) check("t3_data", b_rdata, (k <= 9) ? 32'(k - 2) : 32'd7);
      end

      // ---- reset with reads in flight (B) ----
      b_addr = 30'd3; b_rd = 1'b1;
      tick();
      b_addr = 30'd5;
      tick();
      b_rd = 1'b0;
      check("t5_pre_valid", 32'(b_rvalid), 32'd0);
      b_rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(b_rvalid), 32'd0);
      check("t5_rst_ready", 32'(b_ready), 32'd0);
      check("t5_rst_data", b_rdata, 32'd0);
      tick();
      check("t5_rst_valid2", 32'(b_rvalid), 32'd0);
      b_rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t5_init_valid", 32'(b_rvalid), 32'd0);
         check("t5_init_ready", 32'(b_ready), 32'd0);
         tick();
      end
      check("t5_run_ready", 32'(b_ready), 32'd1);
      check("t5_no_late_valid", 32'(b_rvalid), 32'd0);
      b_addr = 30'd5; b_rd = 1'b1;
      tick();
      b_rd = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t5_rd_valid", 32'(b_rvalid), 32'(k == 2));
         if (k == 2) check("t5_rd_cleared", b_rdata, 32'd0);
         tick();
      end

      // ---- randomized traffic with stalls (C) vs scoreboard ----
      for (int i = 0; i < C_DEPTH; i++) model[i] = '0;
      c_rst_n = 1'b1;
      for (int i = 0; i < C_DEPTH; i++) begin
         check("c_init_ready", 32'(c_ready), 32'd0);
         tick();
      end
      have = 1'b0; ops = 0; guard = 0; run_cyc = 0; stall_cyc = 0;
      while (ops < C_OPS && guard < 12000) begin
         if (!have) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
               c_wr = 1'b0; c_rd = 1'b0;
            end else begin
               have    = 1'b1;
               c_addr  = 30'($urandom);
               c_wdata = $urandom;
               c_be    = 4'($urandom);
               c_wr    = (r <= 4) || (r == 9);
               c_rd    = (r >= 5);
            end
         end
         @(negedge clk);
         guard++;
         run_cyc++;
         if (!c_ready) stall_cyc++;
         c_monitor();
         if (have && c_ready) begin
            idx = c_addr % C_DEPTH;
            if (c_wr) begin
               for (int b = 0; b < 4; b++)
                  if (c_be[b]) model[idx][8*b +: 8] = c_wdata[8*b +: 8];
            end else begin
               rq.push_back('{due: cyc + C_LAT, data: model[idx]});
            end
            have = 1'b0;
            ops++;
         end
         tick();
      end
      c_wr = 1'b0; c_rd = 1'b0;
      check("c_ops_done", ops, C_OPS);
      repeat (C_LAT + 2) begin
         @(negedge clk);
         c_monitor();
      end
      check("c_queue_empty", rq.size(), 32'd0);
      check("c_stall_pct_20_30",
            32'((stall_cyc * 100 >= run_cyc * 20) && (stall_cyc * 100 <= run_cyc * 30)), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
